// File: rtl/dmem_ctrl.sv
// Data-memory responder for the MEM stage: req/ack handshake, WAIT_CYCLES wait states,
// byte-lane stores, word loads. Define DMEM_ALIGN_CHECK_EN to flag misaligned accesses via err_o.
module dmem_ctrl #(
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  sel_i,
   output logic        ack_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  sel_q;
   logic        ack_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic [31:0] mem_q [2**DEPTH_LOG2];

   logic [DEPTH_LOG2-1:0] idx;
   logic                  resp_edge;
   logic                  misalign;
   logic                  unused_addr;

   assign idx       = addr_q[DEPTH_LOG2+1:2];
   // WAIT always lasts cnt+1 cycles so the response edge lands at accept+WAIT_CYCLES+1
   assign resp_edge = (state_q == S_WAIT) && (cnt_q == 4'd0);

`ifdef DMEM_ALIGN_CHECK_EN
   assign misalign = ((sel_q == 4'b1111) && (addr_q[1:0] != 2'b00)) ||
                     (((sel_q == 4'b0011) || (sel_q == 4'b1100)) && addr_q[0]);
`else
   assign misalign = 1'b0;
`endif

   assign unused_addr = ^{addr_q[31:DEPTH_LOG2+2], addr_q[1:0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req_i) begin
               state_d = S_WAIT;
               cnt_d   = 4'(WAIT_CYCLES);
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         sel_q   <= 4'h0;
         ack_q   <= 1'b0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= resp_edge;
         if ((state_q == S_IDLE) && req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            sel_q   <= sel_i;
         end
         if (resp_edge) begin
            err_q <= misalign;
            if (misalign)   rdata_q <= 32'h0;
            else if (!we_q) rdata_q <= mem_q[idx];
         end else if (state_q == S_RESP) begin
            err_q <= 1'b0;
         end
      end
   end

   // Storage has no reset; rst still blocks a write on a coinciding response edge
   always_ff @(posedge clk_i) begin
      if (!rst_i && resp_edge && we_q && !misalign) begin
         for (int i = 0; i < 4; i++) begin
            if (sel_q[i]) mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   assign ack_o   = ack_q;
   assign rdata_o = rdata_q;
   assign err_o   = err_q;

endmodule
